inst_fetch: RTL

- Fetch stage directly upstream of the instruction decoder.
- Generates sequential PCs and issues word requests to instruction memory over a req/gnt + rvalid in-order interface.
- Buffers returned words with their PCs and presents one {instruction, PC} per cycle to the decoder, with a stall hold and a branch/jump redirect (flush) path.

---
 rtl/inst_fetch.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues sequential word fetches over a req/gnt + in-order rvalid
// interface, buffers returned words with their PCs and hands one {inst, pc} per cycle to decode.
module inst_fetch #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0] NOP_INST   = 32'h0000_0013
) (
    input  logic            iClk,
    input  logic            iRst,
    output logic            oImemReq,
    output logic [XLEN-1:0] oImemAddr,
    input  logic            iImemGnt,
    input  logic            iImemRvalid,
    input  logic [XLEN-1:0] iImemRdata,
    input  logic            iFlush,
    input  logic [XLEN-1:0] iFlushPc,
    input  logic            iStall,
    output logic [XLEN-1:0] oInst,
    output logic [XLEN-1:0] oCurPc,
    output logic            oValid
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [AW-1:0] ptr_t;

    localparam cnt_t            DEPTH_C  = cnt_t'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] PC_ALIGN = ~XLEN'(3);

    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    cnt_t            outstanding_q, outstanding_d;
    cnt_t            discard_q, discard_d;
    cnt_t            count_q, count_d;
    ptr_t            wr_ptr_q, wr_ptr_d;
    ptr_t            rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] cur_pc_q, cur_pc_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] fifo_inst_q [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_inst_d [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc_q   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc_d   [FIFO_DEPTH];

    logic [CW:0]     occupancy;
    logic            issue;
    logic            grant;
    logic            rsp_accept;
    logic            rsp_drop;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] flush_target;

    // Every issued request reserves a FIFO slot, so a returning word always has room.
    always_comb begin
        occupancy    = {1'b0, outstanding_q} + {1'b0, count_q};
        issue        = iRst & ~iFlush & (occupancy < {1'b0, DEPTH_C});
        grant        = issue & iImemGnt;
        rsp_accept   = iImemRvalid & (outstanding_q != '0);
        rsp_drop     = rsp_accept & (discard_q != '0);
        push         = rsp_accept & ~rsp_drop & ~iFlush;
        pop          = ~iFlush & ~iStall & (count_q != '0);
        flush_target = iFlushPc & PC_ALIGN;
    end

    always_comb begin
        req_pc_d      = grant ? req_pc_q + PC_STEP : req_pc_q;
        rsp_pc_d      = push ? rsp_pc_q + PC_STEP : rsp_pc_q;
        outstanding_d = outstanding_q + cnt_t'(grant) - cnt_t'(rsp_accept);
        discard_d     = discard_q - cnt_t'(rsp_drop);
        count_d       = count_q + cnt_t'(push) - cnt_t'(pop);
        wr_ptr_d      = push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
        fifo_inst_d   = fifo_inst_q;
        fifo_pc_d     = fifo_pc_q;
        inst_d        = inst_q;
        cur_pc_d      = cur_pc_q;
        valid_d       = valid_q;

        if (push) begin
            fifo_inst_d[wr_ptr_q] = iImemRdata;
            fifo_pc_d[wr_ptr_q]   = rsp_pc_q;
        end

        if (pop) begin
            inst_d   = fifo_inst_q[rd_ptr_q];
            cur_pc_d = fifo_pc_q[rd_ptr_q];
            valid_d  = 1'b1;
        end else if (~iStall | iFlush) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end

        // Requests still in flight after a redirect return stale words; count them for dropping.
        if (iFlush) begin
            req_pc_d  = flush_target;
            rsp_pc_d  = flush_target;
            discard_d = outstanding_q - cnt_t'(rsp_accept);
            count_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            req_pc_q      <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            inst_q        <= NOP_INST;
            cur_pc_q      <= '0;
            valid_q       <= 1'b0;
        end else begin
            req_pc_q      <= req_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            inst_q        <= inst_d;
            cur_pc_q      <= cur_pc_d;
            valid_q       <= valid_d;
        end
    end

    always_ff @(posedge iClk) begin
        fifo_inst_q <= fifo_inst_d;
        fifo_pc_q   <= fifo_pc_d;
    end

    assign oImemReq  = issue;
    assign oImemAddr = req_pc_q;
    assign oInst     = inst_q;
    assign oCurPc    = cur_pc_q;
    assign oValid    = valid_q;

    a_no_overflow: assert property (@(posedge iClk) disable iff (!iRst)
        !(push && !pop && (count_q == DEPTH_C)));
    a_outstanding_bound: assert property (@(posedge iClk) disable iff (!iRst)
        (outstanding_q <= DEPTH_C) && (discard_q <= outstanding_q));

endmodule
